// File: rtl/contador_param.sv
// Parametrised up/down counter with bounds, load, wrap/saturate mode, boundary flags and event pulse.
// Latency: saida, no_maximo, no_minimo and evento all register one clock after the sampled inputs.
// Backpressure: none; every input is sampled on every rising edge. Optional macro: CONTADOR_PARAM_EDGE_EN.
module contador_param #(
   parameter int WIDTH     = 8,
   parameter int STEP      = 1,
   parameter int MIN_VAL   = 0,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             habilitar,
   input  logic             acrescer,
   input  logic             decrescer,
   input  logic             carregar,
   input  logic [WIDTH-1:0] valor_carga,
   input  logic             satura,
   output logic [WIDTH-1:0] saida,
   output logic             no_maximo,
   output logic             no_minimo,
   output logic             evento
);

   // Two guard bits: one for the carry of saida + STEP, one for the sign of saida - STEP.
   localparam int AW = WIDTH + 2;

   localparam logic [WIDTH-1:0]      MIN_W  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0]      MAX_W  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0]      RST_W  = WIDTH'(RESET_VAL);
   localparam logic signed [AW-1:0]  MIN_E  = AW'(MIN_VAL);
   localparam logic signed [AW-1:0]  MAX_E  = AW'(MAX_VAL);
   localparam logic signed [AW-1:0]  STEP_E = AW'(STEP);
   localparam logic signed [AW-1:0]  ONE_E  = AW'(1);

   logic [WIDTH-1:0] saida_q, saida_d;
   logic             no_maximo_q, no_maximo_d;
   logic             no_minimo_q, no_minimo_d;
   logic             evento_q, evento_d;

   // Step requests after optional edge qualification.
   logic up_req;
   logic dn_req;

`ifdef CONTADOR_PARAM_EDGE_EN
   // Each direction input is first registered, then compared with its previous
   // registered value; a step is requested only for a 0->1 transition, so a
   // held button produces exactly one step.
   logic acr_s_q, acr_s_d;
   logic acr_p_q, acr_p_d;
   logic dec_s_q, dec_s_d;
   logic dec_p_q, dec_p_d;

   // Next values of the edge-detect pipeline.
   always_comb begin
      acr_s_d = acrescer;
      acr_p_d = acr_s_q;
      dec_s_d = decrescer;
      dec_p_d = dec_s_q;
   end

   // Edge-detect registers, cleared by reset so no spurious step follows it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acr_s_q <= 1'b0;
         acr_p_q <= 1'b0;
         dec_s_q <= 1'b0;
         dec_p_q <= 1'b0;
      end else begin
         acr_s_q <= acr_s_d;
         acr_p_q <= acr_p_d;
         dec_s_q <= dec_s_d;
         dec_p_q <= dec_p_d;
      end
   end

   assign up_req = acr_s_q & ~acr_p_q;
   assign dn_req = dec_s_q & ~dec_p_q;
`else
   // Level-sensitive: one step per clock while a direction input is held.
   assign up_req = acrescer;
   assign dn_req = decrescer;
`endif

   // Extended-width views of the current count and the load value.
   logic signed [AW-1:0] cnt_ext;
   logic signed [AW-1:0] carga_ext;
   assign cnt_ext   = signed'({2'b00, saida_q});
   assign carga_ext = signed'({2'b00, valor_carga});

   // Up path: candidate sum, overflow test and the in-range wrapped value.
   logic signed [AW-1:0] up_sum;
   logic signed [AW-1:0] up_wrap;
   logic                 up_over;
   always_comb begin
      up_sum  = cnt_ext + STEP_E;
      up_over = (up_sum > MAX_E);
      up_wrap = MIN_E + (up_sum - MAX_E - ONE_E);
   end

   // Down path: candidate difference (may go negative), underflow test and wrapped value.
   logic signed [AW-1:0] dn_dif;
   logic signed [AW-1:0] dn_wrap;
   logic                 dn_under;
   always_comb begin
      dn_dif   = cnt_ext - STEP_E;
      dn_under = (dn_dif < MIN_E);
      dn_wrap  = MAX_E - (MIN_E - dn_dif - ONE_E);
   end

   // Load path: clamp valor_carga into range and flag whether clamping happened.
   logic [WIDTH-1:0] carga_val;
   logic             carga_clamp;
   always_comb begin
      carga_val   = valor_carga;
      carga_clamp = 1'b0;
      if (carga_ext < MIN_E) begin
         carga_val   = MIN_W;
         carga_clamp = 1'b1;
      end else if (carga_ext > MAX_E) begin
         carga_val   = MAX_W;
         carga_clamp = 1'b1;
      end
   end

   // Next count and event: load beats enable, enable gates stepping, opposing requests cancel.
   always_comb begin
      saida_d  = saida_q;
      evento_d = 1'b0;
      if (carregar) begin
         saida_d  = carga_val;
         evento_d = carga_clamp;
      end else if (habilitar) begin
         if (up_req && !dn_req) begin
            if (!up_over) begin
               saida_d = up_sum[WIDTH-1:0];
            end else if (satura) begin
               saida_d  = MAX_W;
               evento_d = (saida_q != MAX_W);
            end else begin
               saida_d  = up_wrap[WIDTH-1:0];
               evento_d = 1'b1;
            end
         end else if (dn_req && !up_req) begin
            if (!dn_under) begin
               saida_d = dn_dif[WIDTH-1:0];
            end else if (satura) begin
               saida_d  = MIN_W;
               evento_d = (saida_q != MIN_W);
            end else begin
               saida_d  = dn_wrap[WIDTH-1:0];
               evento_d = 1'b1;
            end
         end
      end
   end

   // Boundary flags are derived from the next count so they register alongside it.
   always_comb begin
      no_maximo_d = (saida_d == MAX_W);
      no_minimo_d = (saida_d == MIN_W);
   end

   // Counter state; reset is asynchronous and the flags reflect RESET_VAL while it is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         saida_q     <= RST_W;
         no_maximo_q <= (RST_W == MAX_W);
         no_minimo_q <= (RST_W == MIN_W);
         evento_q    <= 1'b0;
      end else begin
         saida_q     <= saida_d;
         no_maximo_q <= no_maximo_d;
         no_minimo_q <= no_minimo_d;
         evento_q    <= evento_d;
      end
   end

   assign saida     = saida_q;
   assign no_maximo = no_maximo_q;
   assign no_minimo = no_minimo_q;
   assign evento    = evento_q;

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: five parameterisations share one set of stimulus inputs.
// Each table row drives one clock and checks one instance; hand sequences cover resets and edge mode.
module tb_contador_param;

   logic       clk;
   logic       rst;
   logic       habilitar;
   logic       acrescer;
   logic       decrescer;
   logic       carregar;
   logic [7:0] valor_carga;
   logic       satura;

   int checks;
   int failures;

   // Instance 0: defaults (8 bit, 0..255, step 1).
   logic [7:0] s0;
   logic       mx0, mn0, ev0;
   // Instance 1: 0..9, step 1.
   logic [7:0] s1;
   logic       mx1, mn1, ev1;
   // Instance 2: 2..20, step 3, reset 2.
   logic [7:0] s2;
   logic       mx2, mn2, ev2;
   // Instance 3: 0..100, step 1.
   logic [7:0] s3;
   logic       mx3, mn3, ev3;
   // Instance 4: 4 bit, 0..15, step 4.
   logic [3:0] s4;
   logic       mx4, mn4, ev4;

   contador_param u_def (
      .clk(clk), .rst(rst), .habilitar(habilitar), .acrescer(acrescer), .decrescer(decrescer),
      .carregar(carregar), .valor_carga(valor_carga), .satura(satura),
      .saida(s0), .no_maximo(mx0), .no_minimo(mn0), .evento(ev0));

   contador_param #(.WIDTH(8), .STEP(1), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0)) u_wrap (
      .clk(clk), .rst(rst), .habilitar(habilitar), .acrescer(acrescer), .decrescer(decrescer),
      .carregar(carregar), .valor_carga(valor_carga), .satura(satura),
      .saida(s1), .no_maximo(mx1), .no_minimo(mn1), .evento(ev1));

   contador_param #(.WIDTH(8), .STEP(3), .MIN_VAL(2), .MAX_VAL(20), .RESET_VAL(2)) u_sat (
      .clk(clk), .rst(rst), .habilitar(habilitar), .acrescer(acrescer), .decrescer(decrescer),
      .carregar(carregar), .valor_carga(valor_carga), .satura(satura),
      .saida(s2), .no_maximo(mx2), .no_minimo(mn2), .evento(ev2));

   contador_param #(.WIDTH(8), .STEP(1), .MIN_VAL(0), .MAX_VAL(100), .RESET_VAL(0)) u_pri (
      .clk(clk), .rst(rst), .habilitar(habilitar), .acrescer(acrescer), .decrescer(decrescer),
      .carregar(carregar), .valor_carga(valor_carga), .satura(satura),
      .saida(s3), .no_maximo(mx3), .no_minimo(mn3), .evento(ev3));

   contador_param #(.WIDTH(4), .STEP(4), .MIN_VAL(0), .MAX_VAL(15), .RESET_VAL(0)) u_wd (
      .clk(clk), .rst(rst), .habilitar(habilitar), .acrescer(acrescer), .decrescer(decrescer),
      .carregar(carregar), .valor_carga(valor_carga[3:0]), .satura(satura),
      .saida(s4), .no_maximo(mx4), .no_minimo(mn4), .evento(ev4));

   // Observed outputs per instance, packed as {saida, no_maximo, no_minimo, evento}.
   logic [10:0] obs [0:4];
   assign obs[0] = {s0, mx0, mn0, ev0};
   assign obs[1] = {s1, mx1, mn1, ev1};
   assign obs[2] = {s2, mx2, mn2, ev2};
   assign obs[3] = {s3, mx3, mn3, ev3};
   assign obs[4] = {4'b0000, s4, mx4, mn4, ev4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         dut;
      logic       hab;
      logic       acr;
      logic       dec;
      logic       car;
      logic [7:0] carga;
      logic       sat;
      logic [7:0] e_s;
      logic       e_mx;
      logic       e_mn;
      logic       e_ev;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t v(input int dut, input logic hab, input logic acr, input logic dec,
                              input logic car, input logic [7:0] carga, input logic sat,
                              input logic [7:0] e_s, input logic e_mx, input logic e_mn,
                              input logic e_ev);
      vec_t r;
      r.dut = dut; r.hab = hab; r.acr = acr; r.dec = dec; r.car = car; r.carga = carga;
      r.sat = sat; r.e_s = e_s; r.e_mx = e_mx; r.e_mn = e_mn; r.e_ev = e_ev;
      return r;
   endfunction

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual saida=%0d max=%b min=%b ev=%b, required saida=%0d max=%b min=%b ev=%b",
                  name, act[10:3], act[2], act[1], act[0], req[10:3], req[2], req[1], req[0]);
      end
   endtask

   task automatic drive(input logic hab, input logic acr, input logic dec, input logic car,
                        input logic [7:0] carga, input logic sat);
      habilitar   = hab;
      acrescer    = acr;
      decrescer   = dec;
      carregar    = car;
      valor_carga = carga;
      satura      = sat;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      drive(0, 0, 0, 0, 8'd0, 0);

      // Reset asserted between edges must act without a clock.
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("reset_def", obs[0], {8'd0, 1'b0, 1'b1, 1'b0});
      chk("reset_sat", obs[2], {8'd2, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      rst = 1'b0;

`ifndef CONTADOR_PARAM_EDGE_EN
      // Count up 3 from reset on the default instance.
      tbl.push_back(v(0, 1, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 0, 8'd0, 0, 8'd3, 0, 0, 0));
      // Wrap up on 0..9: load 0 then 12 up steps.
      tbl.push_back(v(1, 1, 0, 0, 1, 8'd0, 0, 8'd0, 0, 1, 0));
      for (int k = 1; k <= 8; k++)
         tbl.push_back(v(1, 1, 1, 0, 0, 8'd0, 0, 8'(k), 0, 0, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 8'd0, 0, 8'd9, 1, 0, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 1, 1));
      tbl.push_back(v(1, 1, 1, 0, 0, 8'd0, 0, 8'd1, 0, 0, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 8'd0, 0, 8'd2, 0, 0, 0));
      // Saturate down on 2..20 step 3, then load clamping at both ends.
      tbl.push_back(v(2, 1, 0, 0, 1, 8'd7,  1, 8'd7,  0, 0, 0));
      tbl.push_back(v(2, 1, 0, 1, 0, 8'd0,  1, 8'd4,  0, 0, 0));
      tbl.push_back(v(2, 1, 0, 1, 0, 8'd0,  1, 8'd2,  0, 1, 1));
      tbl.push_back(v(2, 1, 0, 1, 0, 8'd0,  1, 8'd2,  0, 1, 0));
      tbl.push_back(v(2, 1, 0, 0, 1, 8'd0,  1, 8'd2,  0, 1, 1));
      tbl.push_back(v(2, 1, 0, 0, 1, 8'd30, 1, 8'd20, 1, 0, 1));
      tbl.push_back(v(2, 1, 0, 0, 1, 8'd15, 1, 8'd15, 0, 0, 0));
      // Priority on 0..100.
      tbl.push_back(v(3, 1, 0, 0, 1, 8'd5,   0, 8'd5,   0, 0, 0));
      tbl.push_back(v(3, 1, 1, 1, 0, 8'd0,   0, 8'd5,   0, 0, 0));
      tbl.push_back(v(3, 1, 1, 0, 1, 8'd200, 0, 8'd100, 1, 0, 1));
      tbl.push_back(v(3, 0, 1, 0, 0, 8'd0,   0, 8'd100, 1, 0, 0));
      tbl.push_back(v(3, 1, 1, 0, 0, 8'd0,   1, 8'd100, 1, 0, 0));
      tbl.push_back(v(3, 1, 1, 0, 0, 8'd0,   0, 8'd0,   0, 1, 1));
      // Wrap down/up with step 4 on a 4-bit counter.
      tbl.push_back(v(4, 1, 0, 0, 1, 8'd2, 0, 8'd2,  0, 0, 0));
      tbl.push_back(v(4, 1, 0, 1, 0, 8'd0, 0, 8'd14, 0, 0, 1));
      tbl.push_back(v(4, 1, 1, 0, 0, 8'd0, 0, 8'd2,  0, 0, 1));
      tbl.push_back(v(4, 1, 0, 0, 0, 8'd0, 0, 8'd2,  0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].hab, tbl[i].acr, tbl[i].dec, tbl[i].car, tbl[i].carga, tbl[i].sat);
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_dut%0d", i, tbl[i].dut), obs[tbl[i].dut],
             {tbl[i].e_s, tbl[i].e_mx, tbl[i].e_mn, tbl[i].e_ev});
      end
`endif

      // Load 3, then assert reset mid-cycle: count must drop before the next edge.
      @(negedge clk);
      drive(0, 0, 0, 1, 8'd3, 0);
      @(posedge clk);
      #1;
      chk("load3", obs[0], {8'd3, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      drive(0, 0, 0, 0, 8'd0, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", obs[0], {8'd0, 1'b0, 1'b1, 1'b0});
      chk("async_rst_sat", obs[2], {8'd2, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      rst = 1'b0;

`ifdef CONTADOR_PARAM_EDGE_EN
      // Holding acrescer for 5 cycles yields one step; a fresh pulse yields another.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1, 1, 0, 0, 8'd0, 0);
      end
      @(negedge clk);
      chk("edge_hold", obs[0], {8'd1, 1'b0, 1'b0, 1'b0});
      drive(1, 0, 0, 0, 8'd0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("edge_release", obs[0], {8'd1, 1'b0, 1'b0, 1'b0});
      drive(1, 1, 0, 0, 8'd0, 0);
      @(negedge clk);
      drive(1, 0, 0, 0, 8'd0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("edge_pulse", obs[0], {8'd2, 1'b0, 1'b0, 1'b0});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
